// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter that sequences operations through one shared
// combinational ALU: accept -> EXEC (ALU settles) -> RESP (one-cycle pulse).
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_m,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_m,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_zf,
  output logic             resp_cf,
  output logic             resp_of,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_m,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             alu_of
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             cur_q;
  logic             grant0, grant1, accept;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic [2:0]       m_q;
  logic             zf_q, cf_q, of_q;
  logic             resp0_q, resp1_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant logic: on contention the client that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
    accept     = grant0 || grant1;
    req0_ready = grant0;
    req1_ready = grant1;
  end

  // Operand capture on accept, result capture at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      m_q          <= '0;
      y_q          <= '0;
      zf_q         <= 1'b0;
      cf_q         <= 1'b0;
      of_q         <= 1'b0;
      resp0_q      <= 1'b0;
      resp1_q      <= 1'b0;
    end else begin
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
      if (accept) begin
        last_grant_q <= grant1;
        cur_q        <= grant1;
        a_q          <= grant1 ? req1_a : req0_a;
        b_q          <= grant1 ? req1_b : req0_b;
        m_q          <= grant1 ? req1_m : req0_m;
      end
      if (state_q == StExec) begin
        y_q     <= alu_y;
        zf_q    <= alu_zf;
        cf_q    <= alu_cf;
        of_q    <= alu_of;
        resp0_q <= !cur_q;
        resp1_q <= cur_q;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_m       = m_q;
  assign resp_y      = y_q;
  assign resp_zf     = zf_q;
  assign resp_cf     = cf_q;
  assign resp_of     = of_q;
  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;

endmodule
